// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the seven-segment scanner.
//   seg_t       - 7-bit active-low segment pattern, [6]=a .. [0]=g
//   SEG_BLANK   - all segments off
//   SEG_HEX     - hex 0..F glyph table
//   lz_mask()   - leading-zero blank mask for up to 8 packed hex digits
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_HEX [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Bit i set when digit i and every digit above it are zero. Digit 0 is
  // never flagged. Callers with fewer than 8 digits zero-extend, which
  // leaves the result for the real digits unchanged.
  function automatic logic [7:0] lz_mask(input logic [31:0] digits);
    logic [7:0] mask;
    logic       upper_zero;
    mask       = '0;
    upper_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      upper_zero = upper_zero && (digits[4*i +: 4] == 4'h0);
      mask[i]    = upper_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex-to-seven-segment decoder.
//   value_i  4-bit hex value
//   seg_o    active-low segment pattern, [6]=a .. [0]=g
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_HEX[value_i];
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed N-digit seven-segment scanner.
//   clk          system clock
//   reset        asynchronous active-high reset
//   digits       packed hex digits, digit 0 in bits [3:0]
//   digit_en     per-digit enable
//   blink_en     per-digit blink enable
//   lz_suppress  blank leading zeros
//   seg          active-low segment bus (registered)
//   an           active-low digit strobes (registered, at most one low)
//   scan_idx     digit slot currently scanned
//   frame_tick   one-cycle pulse one cycle after each frame snapshot
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIV          = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4*N_DIGITS-1:0]       digits,
  input  logic [N_DIGITS-1:0]         digit_en,
  input  logic [N_DIGITS-1:0]         blink_en,
  input  logic                        lz_suppress,
  output logic [6:0]                  seg,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] scan_idx,
  output logic                        frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0]       CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]       DEAD_C   = CW'(DEAD);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0]       FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

  if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_chk_n_digits
    $error("seg7_scan: N_DIGITS must be in 2..8");
  end
  if (DIV < 4) begin : g_chk_div
    $error("seg7_scan: DIV must be at least 4");
  end
  if (DEAD < 1 || DEAD > DIV - 2) begin : g_chk_dead
    $error("seg7_scan: DEAD must be in 1..DIV-2");
  end
  if (BLINK_FRAMES < 1) begin : g_chk_blink
    $error("seg7_scan: BLINK_FRAMES must be at least 1");
  end

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    blink_q, blink_d;
  logic                    wrapped_q, wrapped_d;
  logic [4*N_DIGITS-1:0]   snap_digits_q, snap_digits_d;
  logic [N_DIGITS-1:0]     snap_en_q, snap_en_d;
  logic [N_DIGITS-1:0]     snap_blink_q, snap_blink_d;
  logic                    snap_lz_q, snap_lz_d;
  seg_t                    seg_q, seg_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    tick_q, tick_d;

  logic                    slot_end;
  logic                    frame_end;
  logic                    snap_now;
  logic [3:0]              cur_val;
  seg_t                    cur_seg;
  logic [7:0]              lz_full;
  logic [N_DIGITS-1:0]     lz_vec;
  logic                    visible;
  logic                    lit;
  logic                    lz_unused;

  // Only the low N_DIGITS bits of the shared 8-digit mask matter here.
  assign lz_unused = &{1'b0, lz_full};

  seg7_decode u_decode (
    .value_i (cur_val),
    .seg_o   (cur_seg)
  );

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    snap_now  = (cnt_q == '0) && (idx_q == '0);

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    frame_d = frame_q;
    blink_d = blink_q;
    if (frame_end) begin
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end

    // Suppresses the pulse for the snapshot taken right at reset release.
    wrapped_d = wrapped_q | frame_end;

    snap_digits_d = snap_digits_q;
    snap_en_d     = snap_en_q;
    snap_blink_d  = snap_blink_q;
    snap_lz_d     = snap_lz_q;
    if (snap_now) begin
      snap_digits_d = digits;
      snap_en_d     = digit_en;
      snap_blink_d  = blink_en;
      snap_lz_d     = lz_suppress;
    end

    // Display path works from the snapshot only, so frames never tear.
    cur_val = snap_digits_q[{idx_q, 2'b00} +: 4];
    lz_full = lz_mask(32'(snap_digits_q));
    lz_vec  = snap_lz_q ? lz_full[N_DIGITS-1:0] : '0;
    visible = snap_en_q[idx_q] && !(snap_blink_q[idx_q] && blink_q) && !lz_vec[idx_q];
    lit     = visible && (cnt_q >= DEAD_C);

    an_d   = lit ? ~(AN_ONE << idx_q) : '1;
    seg_d  = lit ? cur_seg : SEG_BLANK;
    tick_d = snap_now && wrapped_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      blink_q       <= 1'b0;
      wrapped_q     <= 1'b0;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      snap_blink_q  <= '0;
      snap_lz_q     <= 1'b0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      blink_q       <= blink_d;
      wrapped_q     <= wrapped_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      snap_blink_q  <= snap_blink_d;
      snap_lz_q     <= snap_lz_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      tick_q        <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign scan_idx   = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: the stimulus process pushes the expected
// per-slot picture of each frame it sets up; the monitor pops one record per
// frame_tick and checks all 32 cycles of that frame.
module tb_seg7_scan;

  localparam int N = 4, DIV = 8, DEAD = 2, BF = 2, FRAME = 32;

  localparam logic [6:0] HEX [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  blink_en = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  logic        frame_tick;

  seg7_scan #(.N_DIGITS(N), .DIV(DIV), .DEAD(DEAD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .an          (an),
    .scan_idx    (scan_idx),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; state c of the scan is the cycle with cyc==c.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [31:0]     frame;
    logic [3:0]      lit;
    logic [3:0][3:0] an_slot;
    logic [3:0][6:0] seg_slot;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_active = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int frame, input logic [15:0] d, input logic [3:0] en,
                              input logic [3:0] bl, input logic lz, input logic ph);
    rec_t       r;
    int         h;
    logic [3:0] a;
    r = '0;
    h = -1;
    for (int i = 3; i >= 0; i--)
      if (h < 0 && d[4*i +: 4] != 4'h0) h = i;
    r.frame = frame;
    for (int s = 0; s < 4; s++) begin
      r.lit[s]      = en[s] && !(bl[s] && ph) && !(lz && s != 0 && s > h);
      a             = 4'hF;
      a[s]          = 1'b0;
      r.an_slot[s]  = a;
      r.seg_slot[s] = HEX[d[4*s +: 4]];
    end
    return r;
  endfunction

  task automatic push(input int k);
    sb.push_back(mk(k, digits, digit_en, blink_en, lz_suppress, ((k / BF) % 2) == 1));
  endtask

  task automatic wait_state(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin : monitor
    int         ticks;
    int         pos;
    int         s;
    int         w;
    rec_t       cur;
    logic [3:0] ea;
    logic [6:0] es;
    ticks = 0;
    pos   = 0;
    cur   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ticks      = 0;
        pos        = 0;
        mon_active = 0;
      end else begin
        if (frame_tick) begin
          if (mon_active) chk($sformatf("frame_len f%0d", ticks), pos, FRAME);
          ticks++;
          pos        = 0;
          mon_active = 0;
          while (sb.size() > 0 && sb[0].frame < ticks) begin
            chk("missed_frame", sb[0].frame, ticks);
            void'(sb.pop_front());
          end
          if (sb.size() > 0 && sb[0].frame == ticks) begin
            cur        = sb.pop_front();
            mon_active = 1;
          end
        end
        if (mon_active) begin
          if (pos >= FRAME) begin
            chk($sformatf("frame_tick_late f%0d", ticks), frame_tick, 1);
            mon_active = 0;
          end else begin
            s  = pos / DIV;
            w  = pos % DIV;
            ea = (w >= DEAD && cur.lit[s]) ? cur.an_slot[s]  : 4'hF;
            es = (w >= DEAD && cur.lit[s]) ? cur.seg_slot[s] : 7'h7F;
            chk($sformatf("an f%0d c%0d", ticks, pos), an, ea);
            chk($sformatf("seg f%0d c%0d", ticks, pos), seg, es);
            pos++;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    digits      = 16'h4321;
    digit_en    = 4'hF;
    blink_en    = 4'h0;
    lz_suppress = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_idx", scan_idx, 2'd0);
    chk("reset_tick", frame_tick, 1'b0);
    reset = 1'b0;
    push(1);
    push(2);

    // Mid-frame change at cycle 12: frame 2 keeps 4321, frame 3 shows 0050.
    wait_state(2*FRAME + 12);
    digits      = 16'h0050;
    lz_suppress = 1'b1;
    push(3);

    wait_state(3*FRAME + 12);
    digits = 16'h0000;
    push(4);

    wait_state(4*FRAME + 12);
    digits      = 16'h4321;
    lz_suppress = 1'b0;
    blink_en    = 4'b0001;
    for (int k = 5; k <= 9; k++) push(k);

    wait_state(9*FRAME + 12);
    blink_en = 4'b0000;
    digit_en = 4'b1011;
    push(10);
    push(11);

    wait_state(11*FRAME + 12);
    digit_en = 4'hF;
    blink_en = 4'b0001;

    // Frame 14 runs in the dark blink phase; slot 2 lit at cycle 20.
    wait_state(14*FRAME + 20);
    chk("pre_reset_an", an, 4'b1011);
    chk("pre_reset_seg", seg, 7'b0000110);
    reset = 1'b1;
    #1;
    chk("midslot_reset_an", an, 4'hF);
    chk("midslot_reset_seg", seg, 7'h7F);
    chk("midslot_reset_idx", scan_idx, 2'd0);
    chk("midslot_reset_tick", frame_tick, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_idx", scan_idx, 2'd0);
    push(1);
    push(2);

    guard = 0;
    while ((sb.size() != 0 || mon_active) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_queue", sb.size(), 0);
    chk("drain_monitor", mon_active, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
